// File: rtl/trigger_pkg.sv
// Shared types and constants for the trigger engine: FSM states, edge-select
// encodings and m_tuser bit positions.
package trigger_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACTIVE  = 2'd1,
        ST_HOLDOFF = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam logic [1:0] EDGE_RISE = 2'b01;
    localparam logic [1:0] EDGE_FALL = 2'b10;
    localparam logic [1:0] EDGE_BOTH = 2'b11;

    localparam int TUSER_RISE = 0;
    localparam int TUSER_FALL = 1;

endpackage

// File: rtl/trigger_engine_if.sv
// Sample-stream bundle of the trigger engine: input AXI-Stream slave side and
// output AXI-Stream master side with the {falling, rising} tuser flags.
interface trigger_engine_if #(
    parameter int WIDTH = 16
) ();
    logic             s_tvalid;
    logic             s_tready;
    logic [WIDTH-1:0] s_tdata;
    logic             m_tvalid;
    logic             m_tready;
    logic [WIDTH-1:0] m_tdata;
    logic [1:0]       m_tuser;

    // Engine side of the bundle.
    modport slave (
        input  s_tvalid, s_tdata, m_tready,
        output s_tready, m_tvalid, m_tdata, m_tuser
    );

    // Source/sink side driving samples in and draining beats out.
    modport master (
        output s_tvalid, s_tdata, m_tready,
        input  s_tready, m_tvalid, m_tdata, m_tuser
    );
endinterface

// File: rtl/axis_pipe_stage.sv
// One-deep AXI-Stream register slice; accepts whenever the output is empty
// or being drained in the same cycle.
module axis_pipe_stage #(
    parameter int DW = 18
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          accept
);
    logic          valid_r;
    logic [DW-1:0] data_r;

    assign in_ready  = !valid_r || out_ready;
    assign accept    = in_valid && in_ready;
    assign out_valid = valid_r;
    assign out_data  = data_r;

    // Output register: load on accept, drop valid once drained, else hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_r <= 1'b0;
            data_r  <= {DW{1'b0}};
        end else if (accept) begin
            valid_r <= 1'b1;
            data_r  <= in_data;
        end else if (out_ready) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end
endmodule

// File: rtl/trigger_engine.sv
// Sample passthrough with hysteresis-armed edge triggering, holdoff,
// single-shot/re-arm control and a saturating trigger counter.
module trigger_engine
    import trigger_pkg::*;
#(
    parameter int WIDTH         = 16,
    parameter int HOLDOFF_WIDTH = 16,
    parameter int COUNT_WIDTH   = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    trigger_engine_if.slave          bus,
    input  logic                     enable,
    input  logic [WIDTH-1:0]         level,
    input  logic [WIDTH-1:0]         hysteresis,
    input  logic [1:0]               edge_sel,
    input  logic [HOLDOFF_WIDTH-1:0] holdoff,
    input  logic                     single_shot,
    input  logic                     rearm,
    output logic                     armed,
    output logic                     done,
    output logic [COUNT_WIDTH-1:0]   trigger_count
);
    localparam int TW = WIDTH + 2;

    state_t                   state_r;
    logic [WIDTH-1:0]         cfg_level_r;
    logic [WIDTH-1:0]         cfg_hyst_r;
    logic [1:0]               cfg_edge_r;
    logic [HOLDOFF_WIDTH-1:0] cfg_holdoff_r;
    logic                     cfg_single_r;
    logic                     arm_rise_r;
    logic                     arm_fall_r;
    logic [HOLDOFF_WIDTH-1:0] hold_cnt_r;
    logic [COUNT_WIDTH-1:0]   count_r;

    // Two guard bits keep level +/- an unsigned band from wrapping.
    logic signed [TW-1:0] level_x_s, hyst_x_s, sample_x_s, lo_s, hi_s;
    logic                 arm_lo_s, arm_hi_s, rise_s, fall_s, trig_s, accept_s;
    logic [1:0]           tuser_s;
    logic [TW-1:0]        pipe_data_s;

    assign level_x_s  = {{2{cfg_level_r[WIDTH-1]}}, cfg_level_r};
    assign hyst_x_s   = {2'b00, cfg_hyst_r};
    assign sample_x_s = {{2{bus.s_tdata[WIDTH-1]}}, bus.s_tdata};
    assign lo_s       = level_x_s - hyst_x_s;
    assign hi_s       = level_x_s + hyst_x_s;

    // Detection uses the arm flags as they stood before this beat.
    always_comb begin
        arm_lo_s = (sample_x_s < lo_s);
        arm_hi_s = (sample_x_s > hi_s);
        rise_s   = 1'b0;
        fall_s   = 1'b0;
        if (state_r == ST_ACTIVE) begin
            rise_s = cfg_edge_r[TUSER_RISE] && arm_rise_r && (sample_x_s >= level_x_s);
            fall_s = cfg_edge_r[TUSER_FALL] && arm_fall_r && (sample_x_s <= level_x_s);
        end else begin
            rise_s = 1'b0;
            fall_s = 1'b0;
        end
        tuser_s = {fall_s, rise_s};
        trig_s  = rise_s || fall_s;
    end

    axis_pipe_stage #(.DW(TW)) u_pipe (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (bus.s_tvalid),
        .in_ready  (bus.s_tready),
        .in_data   ({tuser_s, bus.s_tdata}),
        .out_valid (bus.m_tvalid),
        .out_ready (bus.m_tready),
        .out_data  (pipe_data_s),
        .accept    (accept_s)
    );

    assign bus.m_tdata = pipe_data_s[WIDTH-1:0];
    assign bus.m_tuser = pipe_data_s[TW-1:WIDTH];

    assign armed = (state_r == ST_ACTIVE) &&
                   ((cfg_edge_r[TUSER_RISE] && arm_rise_r) || (cfg_edge_r[TUSER_FALL] && arm_fall_r));
    assign done          = (state_r == ST_DONE);
    assign trigger_count = count_r;

    // Trigger FSM: config latch, arm flags, holdoff countdown and event count.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            cfg_level_r   <= {WIDTH{1'b0}};
            cfg_hyst_r    <= {WIDTH{1'b0}};
            cfg_edge_r    <= 2'b00;
            cfg_holdoff_r <= {HOLDOFF_WIDTH{1'b0}};
            cfg_single_r  <= 1'b0;
            arm_rise_r    <= 1'b0;
            arm_fall_r    <= 1'b0;
            hold_cnt_r    <= {HOLDOFF_WIDTH{1'b0}};
            count_r       <= {COUNT_WIDTH{1'b0}};
        end else if (!enable) begin
            state_r    <= ST_IDLE;
            arm_rise_r <= 1'b0;
            arm_fall_r <= 1'b0;
            hold_cnt_r <= {HOLDOFF_WIDTH{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_r       <= ST_ACTIVE;
                    cfg_level_r   <= level;
                    cfg_hyst_r    <= hysteresis;
                    cfg_edge_r    <= edge_sel;
                    cfg_holdoff_r <= holdoff;
                    cfg_single_r  <= single_shot;
                    arm_rise_r    <= 1'b0;
                    arm_fall_r    <= 1'b0;
                    count_r       <= {COUNT_WIDTH{1'b0}};
                end
                ST_ACTIVE: begin
                    if (accept_s && trig_s) begin
                        arm_rise_r <= 1'b0;
                        arm_fall_r <= 1'b0;
                        if (count_r != {COUNT_WIDTH{1'b1}}) begin
                            count_r <= count_r + COUNT_WIDTH'(1);
                        end
                        if (cfg_single_r) begin
                            state_r <= ST_DONE;
                        end else if (cfg_holdoff_r != {HOLDOFF_WIDTH{1'b0}}) begin
                            state_r    <= ST_HOLDOFF;
                            hold_cnt_r <= cfg_holdoff_r;
                        end
                    end else if (accept_s) begin
                        arm_rise_r <= arm_rise_r | arm_lo_s;
                        arm_fall_r <= arm_fall_r | arm_hi_s;
                    end
                end
                ST_HOLDOFF: begin
                    if (accept_s) begin
                        arm_rise_r <= arm_rise_r | arm_lo_s;
                        arm_fall_r <= arm_fall_r | arm_hi_s;
                        if (hold_cnt_r <= HOLDOFF_WIDTH'(1)) begin
                            state_r    <= ST_ACTIVE;
                            hold_cnt_r <= {HOLDOFF_WIDTH{1'b0}};
                        end else begin
                            hold_cnt_r <= hold_cnt_r - HOLDOFF_WIDTH'(1);
                        end
                    end
                end
                ST_DONE: begin
                    if (rearm) begin
                        state_r    <= ST_ACTIVE;
                        arm_rise_r <= 1'b0;
                        arm_fall_r <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end
endmodule
